// File: rtl/dti_msg_splitter_if.sv
// Stream bundle between the DTI AXIS ingress and the custom link.
// slave: splitter view; master: driver/sink view.
interface dti_msg_splitter_if #(
  parameter int TBU_NUM_WIDTH = 6,
  parameter int IN_WIDTH      = 160,
  parameter int OUT_WIDTH     = 80
);
  logic                     s_tvalid;
  logic                     s_tready;
  logic [IN_WIDTH-1:0]      s_tdata;
  logic [IN_WIDTH/8-1:0]    s_tkeep;
  logic [TBU_NUM_WIDTH-1:0] s_tid;
  logic                     m_valid;
  logic                     m_ready;
  logic [OUT_WIDTH-1:0]     m_data;
  logic [OUT_WIDTH/8-1:0]   m_keep;
  logic [TBU_NUM_WIDTH-1:0] m_tid;
  logic                     m_last;

  modport slave (
    input  s_tvalid, s_tdata, s_tkeep, s_tid, m_ready,
    output s_tready, m_valid, m_data, m_keep, m_tid, m_last
  );

  modport master (
    output s_tvalid, s_tdata, s_tkeep, s_tid, m_ready,
    input  s_tready, m_valid, m_data, m_keep, m_tid, m_last
  );
endinterface

// File: rtl/dti_msg_splitter.sv
// DTI message splitter: one message in, one or two beats out, per-TBU state.
// Optional drop counter enabled by DTI_SPLIT_DROP_CNT_EN.
module dti_msg_splitter #(
  parameter int TBU_NUM       = 2,
  parameter int TBU_NUM_WIDTH = 6,
  parameter int IN_WIDTH      = 160,
  parameter int OUT_WIDTH     = 80
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dti_msg_splitter_if.slave      bus,
  output logic [2*TBU_NUM-1:0]   entry_state
`ifdef DTI_SPLIT_DROP_CNT_EN
  ,
  output logic [15:0]            drop_cnt
`endif
);

  localparam int TW  = TBU_NUM_WIDTH;
  localparam int IKW = IN_WIDTH / 8;
  localparam int OKW = OUT_WIDTH / 8;
  localparam logic [3:0] CONDIS_REQ = 4'h0;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    CONNECTED    = 2'b01,
    TRANSACTION  = 2'b10,
    DISCONNECTED = 2'b11
  } entry_state_t;

  entry_state_t ent_q [TBU_NUM];
  entry_state_t ent_d [TBU_NUM];
  entry_state_t cur;
  entry_state_t nxt;

  logic                 m_valid_q;
  logic [OUT_WIDTH-1:0] m_data_q;
  logic [OKW-1:0]       m_keep_q;
  logic [TW-1:0]        m_tid_q;
  logic                 m_last_q;
  logic [OUT_WIDTH-1:0] hi_data_q;
  logic [OKW-1:0]       hi_keep_q;

  logic rel, adv, rdy, acc;
  logic is_condis, is_con;
  logic in_range, drop, load;

  assign bus.s_tready = rdy;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_data   = m_data_q;
  assign bus.m_keep   = m_keep_q;
  assign bus.m_tid    = m_tid_q;
  assign bus.m_last   = m_last_q;

  // Handshakes, release-then-accept state resolution and drop decision
  always_comb begin
    rel       = m_valid_q && bus.m_ready && m_last_q;
    adv       = m_valid_q && bus.m_ready && !m_last_q;
    rdy       = !m_valid_q || rel;
    acc       = bus.s_tvalid && rdy;
    is_condis = bus.s_tdata[3:0] == CONDIS_REQ;
    is_con    = is_condis && bus.s_tdata[4];
    in_range  = 1'b0;
    cur       = IDLE;
    for (int i = 0; i < TBU_NUM; i++) begin
      ent_d[i] = ent_q[i];
      if (rel && m_tid_q == TW'(i)) begin
        if (ent_q[i] == TRANSACTION)
          ent_d[i] = CONNECTED;
        else if (ent_q[i] == DISCONNECTED)
          ent_d[i] = IDLE;
      end
    end
    for (int i = 0; i < TBU_NUM; i++) begin
      if (bus.s_tid == TW'(i)) begin
        in_range = 1'b1;
        cur      = ent_d[i];
      end
    end
    drop = !in_range || (bus.s_tkeep == '0) ||
           (cur == IDLE && !is_con);
    load = acc && !drop;
    if (is_con)
      nxt = CONNECTED;
    else if (is_condis)
      nxt = DISCONNECTED;
    else
      nxt = TRANSACTION;
    for (int i = 0; i < TBU_NUM; i++) begin
      if (load && bus.s_tid == TW'(i))
        ent_d[i] = nxt;
    end
  end

  // Per-TBU connection entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TBU_NUM; i++)
        ent_q[i] <= IDLE;
    end else begin
      for (int i = 0; i < TBU_NUM; i++)
        ent_q[i] <= ent_d[i];
    end
  end

  // Message buffer: low half presented first, high half parked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_tid_q   <= '0;
      m_last_q  <= 1'b0;
      hi_data_q <= '0;
      hi_keep_q <= '0;
    end else if (load) begin
      m_valid_q <= 1'b1;
      m_data_q  <= bus.s_tdata[OUT_WIDTH-1:0];
      m_keep_q  <= bus.s_tkeep[OKW-1:0];
      m_tid_q   <= bus.s_tid;
      m_last_q  <= ~|bus.s_tkeep[IKW-1:OKW];
      hi_data_q <= bus.s_tdata[IN_WIDTH-1:OUT_WIDTH];
      hi_keep_q <= bus.s_tkeep[IKW-1:OKW];
    end else if (adv) begin
      m_data_q  <= hi_data_q;
      m_keep_q  <= hi_keep_q;
      m_last_q  <= 1'b1;
    end else if (rel) begin
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end
  end

  // Flatten entries onto the status port
  always_comb begin
    entry_state = '0;
    for (int i = 0; i < TBU_NUM; i++)
      entry_state[2*i +: 2] = ent_q[i];
  end

`ifdef DTI_SPLIT_DROP_CNT_EN
  logic [15:0] drop_cnt_q;
  assign drop_cnt = drop_cnt_q;

  // Saturating count of consumed-but-dropped messages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt_q <= '0;
    else if (acc && drop && drop_cnt_q != 16'hFFFF)
      drop_cnt_q <= drop_cnt_q + 16'd1;
  end
`endif

endmodule

// File: tb/tb_dti_msg_splitter.sv
// Directed vector bench for dti_msg_splitter.
// Entry codes: IDLE 0, CONNECTED 1, TRANSACTION 2, DISCONNECTED 3.
module tb_dti_msg_splitter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] es;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  dti_msg_splitter_if #(.TBU_NUM_WIDTH(6)) bus ();

`ifdef DTI_SPLIT_DROP_CNT_EN
  logic [15:0] dcnt;
`endif

  dti_msg_splitter #(.TBU_NUM(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .entry_state(es)
`ifdef DTI_SPLIT_DROP_CNT_EN
    ,
    .drop_cnt(dcnt)
`endif
  );

  typedef struct {
    logic         v;
    logic [159:0] d;
    logic [19:0]  k;
    logic [5:0]   id;
    logic         mr;
    logic         rdy;
    logic         mv;
    logic         ml;
    logic [79:0]  md;
    logic [9:0]   mk;
    logic [5:0]   mt;
    logic [3:0]   es;
  } vec_t;

  localparam logic [79:0] A = 80'hAAAA_AAAA_AAAA_AAAA_AA01;
  localparam logic [79:0] B = 80'hBBBB_BBBB_BBBB_BBBB_BBBB;
  localparam logic [159:0] CON = 160'h10;
  localparam logic [159:0] DIS = 160'h0;
  localparam logic [159:0] NRM = 160'h1;
  localparam logic [159:0] BA = {B, A};

  vec_t tv [13];

  function automatic vec_t mkv(
    logic v, logic [159:0] d, logic [19:0] k,
    logic [5:0] id, logic mr, logic rdy,
    logic mv, logic ml, logic [79:0] md,
    logic [9:0] mk, logic [5:0] mt, logic [3:0] e
  );
    vec_t r;
    r.v = v; r.d = d; r.k = k; r.id = id;
    r.mr = mr; r.rdy = rdy; r.mv = mv; r.ml = ml;
    r.md = md; r.mk = mk; r.mt = mt; r.es = e;
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [79:0] got,
                     input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [159:0] d,
                       input logic [19:0] k, input logic [5:0] id,
                       input logic mr);
    bus.s_tvalid = v;
    bus.s_tdata  = d;
    bus.s_tkeep  = k;
    bus.s_tid    = id;
    bus.m_ready  = mr;
  endtask

  initial begin
    //        v  data  keep      id mr rdy mv ml md       mk     mt es
    tv[0]  = mkv(0, DIS, 20'h0,     0, 1, 1, 0, 0, 80'h0,  10'h0,   0, 4'b0000);
    tv[1]  = mkv(1, CON, 20'h003FF, 0, 1, 1, 1, 1, 80'h10, 10'h3FF, 0, 4'b0001);
    tv[2]  = mkv(1, BA,  20'hFFFFF, 0, 1, 1, 1, 0, A,      10'h3FF, 0, 4'b0010);
    tv[3]  = mkv(1, NRM, 20'h003FF, 1, 1, 0, 1, 1, B,      10'h3FF, 0, 4'b0010);
    tv[4]  = mkv(1, NRM, 20'h003FF, 1, 1, 1, 0, 0, 80'h0,  10'h0,   0, 4'b0001);
    tv[5]  = mkv(1, DIS, 20'h003FF, 0, 1, 1, 1, 1, 80'h0,  10'h3FF, 0, 4'b0011);
    tv[6]  = mkv(1, NRM, 20'h003FF, 0, 1, 1, 0, 0, 80'h0,  10'h0,   0, 4'b0000);
    tv[7]  = mkv(1, CON, 20'h003FF, 0, 1, 1, 1, 1, 80'h10, 10'h3FF, 0, 4'b0001);
    tv[8]  = mkv(1, CON, 20'h003FF, 2, 1, 1, 0, 0, 80'h0,  10'h0,   0, 4'b0001);
    tv[9]  = mkv(1, CON, 20'h0,     1, 1, 1, 0, 0, 80'h0,  10'h0,   0, 4'b0001);
    tv[10] = mkv(1, CON, 20'h003FF, 1, 0, 1, 1, 1, 80'h10, 10'h3FF, 1, 4'b0101);
    tv[11] = mkv(0, DIS, 20'h0,     0, 0, 0, 1, 1, 80'h10, 10'h3FF, 1, 4'b0101);
    tv[12] = mkv(0, DIS, 20'h0,     0, 1, 1, 0, 0, 80'h0,  10'h0,   0, 4'b0101);

    drive(0, DIS, 20'h0, 0, 1);
    #1;
    chk("rst_tready", 80'(bus.s_tready), 80'h1);
    chk("rst_mvalid", 80'(bus.m_valid), 80'h0);
    chk("rst_mlast", 80'(bus.m_last), 80'h0);
    chk("rst_mdata", bus.m_data, 80'h0);
    chk("rst_mkeep", 80'(bus.m_keep), 80'h0);
    chk("rst_mtid", 80'(bus.m_tid), 80'h0);
    chk("rst_entry", 80'(es), 80'h0);
`ifdef DTI_SPLIT_DROP_CNT_EN
    chk("rst_dropcnt", 80'(dcnt), 80'h0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(tv[i].v, tv[i].d, tv[i].k, tv[i].id, tv[i].mr);
      #1;
      chk($sformatf("v%0d_tready", i), 80'(bus.s_tready), 80'(tv[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_mvalid", i), 80'(bus.m_valid), 80'(tv[i].mv));
      chk($sformatf("v%0d_entry", i), 80'(es), 80'(tv[i].es));
      if (tv[i].mv) begin
        chk($sformatf("v%0d_mlast", i), 80'(bus.m_last), 80'(tv[i].ml));
        chk($sformatf("v%0d_mdata", i), bus.m_data, tv[i].md);
        chk($sformatf("v%0d_mkeep", i), 80'(bus.m_keep), 80'(tv[i].mk));
        chk($sformatf("v%0d_mtid", i), 80'(bus.m_tid), 80'(tv[i].mt));
      end
    end
`ifdef DTI_SPLIT_DROP_CNT_EN
    chk("dropcnt_table", 80'(dcnt), 80'd4);
`endif

    // Back-pressure: 2-beat message on TBU0 held for 5 cycles
    @(negedge clk);
    drive(1, BA, 20'hFFFFF, 0, 0);
    #1;
    chk("bp_accept_rdy", 80'(bus.s_tready), 80'h1);
    @(posedge clk);
    #1;
    chk("bp_beat0", bus.m_data, A);
    chk("bp_entry_trans", 80'(es), 80'h6);
    @(negedge clk);
    drive(1, CON, 20'h003FF, 1, 0);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp%0d_tready", c), 80'(bus.s_tready), 80'h0);
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_mvalid", c), 80'(bus.m_valid), 80'h1);
      chk($sformatf("bp%0d_mdata", c), bus.m_data, A);
      chk($sformatf("bp%0d_mlast", c), 80'(bus.m_last), 80'h0);
      @(negedge clk);
    end
    bus.m_ready = 1'b1;
    #1;
    chk("bp_beat0_rdy", 80'(bus.s_tready), 80'h0);
    @(posedge clk);
    #1;
    chk("bp_beat1", bus.m_data, B);
    chk("bp_beat1_last", 80'(bus.m_last), 80'h1);
    chk("bp_beat1_entry", 80'(es), 80'h6);
    @(negedge clk);
    #1;
    chk("bp_refill_rdy", 80'(bus.s_tready), 80'h1);
    @(posedge clk);
    #1;
    chk("bp_new_data", bus.m_data, 80'h10);
    chk("bp_new_tid", 80'(bus.m_tid), 80'h1);
    chk("bp_new_entry", 80'(es), 80'h5);
    @(negedge clk);
    drive(0, DIS, 20'h0, 0, 1);
    @(posedge clk);
    #1;
    chk("bp_drain", 80'(bus.m_valid), 80'h0);
`ifdef DTI_SPLIT_DROP_CNT_EN
    chk("dropcnt_final", 80'(dcnt), 80'd4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
